// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: code geometry, data extraction, syndrome.
// Codeword position p (1-based) lives at bit p-1 of a MAXW-bit vector.
package hamming_pkg;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    LIMPO,
    CORRIGIDO,
    DUPLO
  } classe_t;

  function automatic int n_of(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int k_of(input int r);
    return n_of(r) - r;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic logic [MAXW-1:0] extrai_dados(
    input logic [MAXW-1:0] cw,
    input int              r
  );
    logic [MAXW-1:0] d;
    int              j;
    d = '0;
    j = 0;
    for (int i = 0; i < MAXW; i++) begin
      if ((i < n_of(r)) && !is_pow2(i + 1)) begin
        d[j[5:0]] = cw[i[5:0]];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [7:0] calc_sindrome(
    input logic [MAXW-1:0] cw,
    input int              r
  );
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < MAXW; i++) begin
      if ((i < n_of(r)) && cw[i[5:0]]) s ^= 8'(i + 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational syndrome and overall parity of one codeword.
// The overall parity covers all N+SECDED bits, extra bit included.
module hamming_sindrome
  import hamming_pkg::*;
#(
  parameter int R      = 4,
  parameter int SECDED = 1,
  localparam int W     = n_of(R) + SECDED
) (
  input  logic [W-1:0] cw,
  output logic [R-1:0] sind,
  output logic         par
);

  assign sind = R'(calc_sindrome(MAXW'(cw), R));
  assign par  = (SECDED != 0) ? ^cw : 1'b0;

endmodule

// File: rtl/corrige_hamming_secded_pipe.sv
// Two-stage streaming Hamming SEC/SECDED decoder with valid/ready
// on both sides and saturating corrected/double-error counters.
module corrige_hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int R      = 4,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16,
  localparam int N     = n_of(R),
  localparam int K     = k_of(R),
  localparam int W     = N + SECDED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     entrada,
  input  logic             entrada_valid,
  output logic             entrada_ready,
  output logic [K-1:0]     saida,
  output logic             saida_valid,
  input  logic             saida_ready,
  output logic [R-1:0]     sindrome,
  output logic             erro_corrigido,
  output logic             erro_duplo,
  input  logic             limpa_cont,
  output logic [CNT_W-1:0] cnt_corrigidos,
  output logic [CNT_W-1:0] cnt_duplos
);

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_cw_q, s1_cw_d;
  logic [R-1:0]     s1_sind_q, s1_sind_d;
  logic             s1_par_q, s1_par_d;
  logic             s2_valid_q, s2_valid_d;
  logic [K-1:0]     saida_q, saida_d;
  logic [R-1:0]     sind_q, sind_d;
  logic             corr_q, corr_d;
  logic             dup_q, dup_d;
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_dup_q, cnt_dup_d;

  logic [R-1:0]     sind_c;
  logic             par_c;
  logic             s1_load;
  logic             s2_load;
  logic             entrega;
  classe_t          classe;
  logic             flip;
  logic [N-1:0]     fixed;

  hamming_sindrome #(
    .R      (R),
    .SECDED (SECDED)
  ) u_sind (
    .cw   (entrada),
    .sind (sind_c),
    .par  (par_c)
  );

  assign s2_load       = !s2_valid_q || saida_ready;
  assign s1_load       = s2_load || !s1_valid_q;
  assign entrada_ready = s1_load;
  assign entrega       = s2_valid_q && saida_ready;

  // With SECDED=0 the parity is tied 0, so the arms stay exclusive.
  always_comb begin
    classe = LIMPO;
    flip   = 1'b0;
    unique case (1'b1)
      (s1_sind_q != '0) && (s1_par_q || (SECDED == 0)): begin
        classe = CORRIGIDO;
        flip   = 1'b1;
      end
      (s1_sind_q == '0) && s1_par_q: begin
        classe = CORRIGIDO;
      end
      (s1_sind_q != '0) && !s1_par_q && (SECDED != 0): begin
        classe = DUPLO;
      end
      default: begin
        classe = LIMPO;
      end
    endcase
  end

  always_comb begin
    fixed = s1_cw_q;
    for (int i = 0; i < N; i++) begin
      if (flip && (int'(s1_sind_q) == i + 1)) fixed[i] = ~fixed[i];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_sind_d  = s1_sind_q;
    s1_par_d   = s1_par_q;
    if (s1_load) begin
      s1_valid_d = entrada_valid;
      s1_cw_d    = entrada[N-1:0];
      s1_sind_d  = sind_c;
      s1_par_d   = par_c;
    end
  end

  // S2 payload only moves on a real word so outputs hold under stall.
  always_comb begin
    s2_valid_d = s2_valid_q;
    saida_d    = saida_q;
    sind_d     = sind_q;
    corr_d     = corr_q;
    dup_d      = dup_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        saida_d = K'(extrai_dados(MAXW'(fixed), R));
        sind_d  = s1_sind_q;
        corr_d  = (classe == CORRIGIDO);
        dup_d   = (classe == DUPLO);
      end
    end
  end

  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_dup_d  = cnt_dup_q;
    if (limpa_cont) begin
      cnt_corr_d = '0;
      cnt_dup_d  = '0;
    end else begin
      if (entrega && corr_q && !(&cnt_corr_q))
        cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (entrega && dup_q && !(&cnt_dup_q))
        cnt_dup_d = cnt_dup_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_sind_q  <= '0;
      s1_par_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      saida_q    <= '0;
      sind_q     <= '0;
      corr_q     <= 1'b0;
      dup_q      <= 1'b0;
      cnt_corr_q <= '0;
      cnt_dup_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cw_q    <= s1_cw_d;
      s1_sind_q  <= s1_sind_d;
      s1_par_q   <= s1_par_d;
      s2_valid_q <= s2_valid_d;
      saida_q    <= saida_d;
      sind_q     <= sind_d;
      corr_q     <= corr_d;
      dup_q      <= dup_d;
      cnt_corr_q <= cnt_corr_d;
      cnt_dup_q  <= cnt_dup_d;
    end
  end

  assign saida_valid    = s2_valid_q;
  assign saida          = saida_q;
  assign sindrome       = sind_q;
  assign erro_corrigido = corr_q;
  assign erro_duplo     = dup_q;
  assign cnt_corrigidos = cnt_corr_q;
  assign cnt_duplos     = cnt_dup_q;

endmodule

// File: tb/tb_corrige_hamming_secded_pipe.sv
// Directed bench for the R=4 SECDED decoder: vector table plus
// backpressure, mid-stream reset, saturation and clear sequences.
module tb_corrige_hamming_secded_pipe;

  typedef struct {
    logic [15:0] cw;
    logic [10:0] dat;
    logic [3:0]  sind;
    logic        c;
    logic        d;
  } vec_t;

  typedef struct {
    logic [10:0] dat;
    logic [3:0]  sind;
    logic        c;
    logic        d;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] entrada;
  logic        entrada_valid;
  logic        entrada_ready;
  logic [10:0] saida;
  logic        saida_valid;
  logic        saida_ready;
  logic [3:0]  sindrome;
  logic        erro_corrigido;
  logic        erro_duplo;
  logic        limpa_cont;
  logic [15:0] cnt_corrigidos;
  logic [15:0] cnt_duplos;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t cur;
  exp_t mon_e;
  vec_t v[20];
  vec_t va, vb, vc;

  corrige_hamming_secded_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .entrada        (entrada),
    .entrada_valid  (entrada_valid),
    .entrada_ready  (entrada_ready),
    .saida          (saida),
    .saida_valid    (saida_valid),
    .saida_ready    (saida_ready),
    .sindrome       (sindrome),
    .erro_corrigido (erro_corrigido),
    .erro_duplo     (erro_duplo),
    .limpa_cont     (limpa_cont),
    .cnt_corrigidos (cnt_corrigidos),
    .cnt_duplos     (cnt_duplos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int p = 1; p <= 15; p++) begin
        if ((((p >> i) & 1) != 0) && (p != (1 << i)))
          cw[(1 << i) - 1] ^= cw[p-1];
      end
    end
    cw[15] = ^cw[14:0];
    return cw;
  endfunction

  function automatic vec_t mk(input logic [15:0] cw, input logic [10:0] dat,
                              input logic [3:0] s, input logic c,
                              input logic d);
    vec_t x;
    x.cw   = cw;
    x.dat  = dat;
    x.sind = s;
    x.c    = c;
    x.d    = d;
    return x;
  endfunction

  // Scoreboard: log accepts, compare deliveries in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (saida_valid && saida_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_out: got %0h want none", saida);
        end else begin
          mon_e = q.pop_front();
          chk("saida", 32'(saida), 32'(mon_e.dat));
          chk("flags", {26'd0, sindrome, erro_corrigido, erro_duplo},
              {26'd0, mon_e.sind, mon_e.c, mon_e.d});
          if (mon_e.lat) chk("latencia", cyc - mon_e.acc, 2);
        end
      end
      if (entrada_valid && entrada_ready) begin
        mon_e     = cur;
        mon_e.acc = cyc;
        q.push_back(mon_e);
      end
    end
  end

  task automatic send(input vec_t x, input bit lat);
    int n;
    entrada       = x.cw;
    cur.dat       = x.dat;
    cur.sind      = x.sind;
    cur.c         = x.c;
    cur.d         = x.d;
    cur.lat       = lat;
    entrada_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!entrada_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!entrada_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 want ready=1");
    end
    @(posedge clk);
    #1;
    entrada_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    entrada       = '0;
    entrada_valid = 1'b0;
    saida_ready   = 1'b1;
    limpa_cont    = 1'b0;
    cur           = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", saida_valid, 0);
    chk("rst_saida", saida, 0);
    chk("rst_flags", {sindrome, erro_corrigido, erro_duplo}, 0);
    chk("rst_cnt", {cnt_corrigidos, cnt_duplos}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    v[0] = mk(encode(11'h5A3), 11'h5A3, 4'h0, 1'b0, 1'b0);
    v[1] = mk(encode(11'h000), 11'h000, 4'h0, 1'b0, 1'b0);
    v[2] = mk(encode(11'h7FF), 11'h7FF, 4'h0, 1'b0, 1'b0);
    for (int p = 1; p <= 15; p++)
      v[2+p] = mk(encode(11'h5A3) ^ (16'h1 << (p - 1)), 11'h5A3,
                  4'(p), 1'b1, 1'b0);
    v[18] = mk(encode(11'h5A3) ^ 16'h8000, 11'h5A3, 4'h0, 1'b1, 1'b0);
    v[19] = mk(encode(11'h2C4) ^ 16'h0104, 11'h2D5, 4'hA, 1'b0, 1'b1);

    for (int i = 0; i < 18; i++) send(v[i], 1'b1);
    drain();
    chk("cnt_corr_15", cnt_corrigidos, 16'd15);
    chk("cnt_dup_0", cnt_duplos, 16'd0);
    for (int i = 18; i < 20; i++) send(v[i], 1'b1);
    drain();
    chk("cnt_corr_16", cnt_corrigidos, 16'd16);
    chk("cnt_dup_1", cnt_duplos, 16'd1);

    va = mk(encode(11'h123), 11'h123, 4'h0, 1'b0, 1'b0);
    vb = mk(encode(11'h456) ^ 16'h0010, 11'h456, 4'h5, 1'b1, 1'b0);
    vc = mk(encode(11'h789), 11'h789, 4'h0, 1'b0, 1'b0);
    saida_ready = 1'b0;
    fork
      begin
        send(va, 1'b0);
        send(vb, 1'b0);
        send(vc, 1'b0);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k >= 2) begin
            chk("bp_ready", entrada_ready, 0);
            chk("bp_valid", saida_valid, 1);
            chk("bp_hold", {sindrome, erro_corrigido, erro_duplo, saida},
                {4'h0, 1'b0, 1'b0, 11'h123});
          end
        end
        @(posedge clk);
        #1;
        saida_ready = 1'b1;
      end
    join
    drain();
    chk("cnt_corr_bp", cnt_corrigidos, 16'd17);

    send(mk(encode(11'h111), 11'h111, 4'h0, 1'b0, 1'b0), 1'b1);
    send(mk(encode(11'h222) ^ 16'h0040, 11'h222, 4'h7, 1'b1, 1'b0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", saida_valid, 0);
    chk("mid_rst_cnt", {cnt_corrigidos, cnt_duplos}, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(mk(encode(11'h333), 11'h333, 4'h0, 1'b0, 1'b0), 1'b1);
    drain();
    chk("post_rst_cnt", cnt_corrigidos, 16'd0);

    @(negedge clk);
    force dut.cnt_corr_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_corr_q;
    @(posedge clk);
    #1;
    send(mk(encode(11'h5A3) ^ 16'h0001, 11'h5A3, 4'h1, 1'b1, 1'b0), 1'b1);
    drain();
    chk("cnt_sat", cnt_corrigidos, 16'hFFFF);

    saida_ready = 1'b0;
    send(mk(encode(11'h0F0) ^ 16'h0800, 11'h0F0, 4'hC, 1'b1, 1'b0), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    limpa_cont  = 1'b1;
    saida_ready = 1'b1;
    @(posedge clk);
    #1;
    limpa_cont = 1'b0;
    chk("limpa_wins", cnt_corrigidos, 16'd0);
    drain();
    chk("cnt_dup_end", cnt_duplos, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
